// File: rtl/fma_align_ctrl_if.sv
// Operand/result handshake bundle for the FMA addend-alignment controller.
// Ready/valid on both sides: the block holds the result until out_ready.
interface fma_align_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  exp_a;
   logic [7:0]  exp_b;
   logic [7:0]  exp_c;
   logic [22:0] man_c;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  shamt;
   logic        ab_req;
   logic        prod_shift;
   logic [25:0] align_m;
   logic        sticky;
   logic        busy;

   modport master (
      output in_valid, exp_a, exp_b, exp_c, man_c, out_ready,
      input  in_ready, out_valid, shamt, ab_req, prod_shift, align_m, sticky, busy
   );

   modport slave (
      input  in_valid, exp_a, exp_b, exp_c, man_c, out_ready,
      output in_ready, out_valid, shamt, ab_req, prod_shift, align_m, sticky, busy
   );
endinterface

// File: rtl/fma_align_ctrl.sv
// FMA addend alignment: shamt = ea+eb-ec, then a serial right shift of the addend (one bit/cycle).
// Result visible at edge k+2+n (n <= MAX_SHIFT); one set in flight, held in DONE until out_ready.
module fma_align_ctrl #(
   parameter int MAX_SHIFT = 26
) (
   input logic          clk,
   input logic          rst,
   fma_align_ctrl_if.slave bus
);
   localparam int CW = $clog2(MAX_SHIFT + 1);
   localparam logic [7:0]    MAX_SHAMT = 8'(MAX_SHIFT);
   localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_SHIFT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CALC  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [7:0]    exp_a_q, exp_a_d, exp_b_q, exp_b_d, exp_c_q, exp_c_d;
   logic [22:0]   man_c_q, man_c_d;
   logic [7:0]    shamt_q, shamt_d;
   logic          ab_req_q, ab_req_d;
   logic          prod_shift_q, prod_shift_d;
   logic [25:0]   align_m_q, align_m_d;
   logic          sticky_q, sticky_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [7:0]    calc_shamt;
   logic          calc_ab_req;
   logic [CW-1:0] calc_n;

   always_comb begin
      calc_shamt  = exp_a_q + exp_b_q - exp_c_q;
      // A large negative difference means the product is negligible next to the addend.
      calc_ab_req = !(calc_shamt[7] && (calc_shamt[6:0] <= 7'd104));
      if (calc_ab_req && !calc_shamt[7])
         calc_n = (calc_shamt >= MAX_SHAMT) ? MAX_CNT : calc_shamt[CW-1:0];
      else
         calc_n = '0;
   end

   always_comb begin
      state_d      = state_q;
      exp_a_d      = exp_a_q;
      exp_b_d      = exp_b_q;
      exp_c_d      = exp_c_q;
      man_c_d      = man_c_q;
      shamt_d      = shamt_q;
      ab_req_d     = ab_req_q;
      prod_shift_d = prod_shift_q;
      align_m_d    = align_m_q;
      sticky_d     = sticky_q;
      cnt_d        = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               exp_a_d = bus.exp_a;
               exp_b_d = bus.exp_b;
               exp_c_d = bus.exp_c;
               man_c_d = bus.man_c;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            shamt_d      = calc_shamt;
            ab_req_d     = calc_ab_req;
            prod_shift_d = calc_ab_req & calc_shamt[7];
            align_m_d    = {1'b1, man_c_q, 2'b00};
            sticky_d     = 1'b0;
            cnt_d        = calc_n;
            state_d      = (calc_n == '0) ? S_DONE : S_SHIFT;
         end
         S_SHIFT: begin
            align_m_d = {1'b0, align_m_q[25:1]};
            sticky_d  = sticky_q | align_m_q[0];
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
               state_d = S_DONE;
         end
         default: begin
            if (bus.out_ready)
               state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         exp_a_q      <= '0;
         exp_b_q      <= '0;
         exp_c_q      <= '0;
         man_c_q      <= '0;
         shamt_q      <= '0;
         ab_req_q     <= 1'b0;
         prod_shift_q <= 1'b0;
         align_m_q    <= '0;
         sticky_q     <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         exp_a_q      <= exp_a_d;
         exp_b_q      <= exp_b_d;
         exp_c_q      <= exp_c_d;
         man_c_q      <= man_c_d;
         shamt_q      <= shamt_d;
         ab_req_q     <= ab_req_d;
         prod_shift_q <= prod_shift_d;
         align_m_q    <= align_m_d;
         sticky_q     <= sticky_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.in_ready   = (state_q == S_IDLE);
   assign bus.out_valid  = (state_q == S_DONE);
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.shamt      = shamt_q;
   assign bus.ab_req     = ab_req_q;
   assign bus.prod_shift = prod_shift_q;
   assign bus.align_m    = align_m_q;
   assign bus.sticky     = sticky_q;
endmodule

// File: tb/tb_fma_align_ctrl.sv
// Directed-vector bench for fma_align_ctrl: hand-computed alignment results, latency, hold and reset.
module tb_fma_align_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   fma_align_ctrl_if bus();

   fma_align_ctrl #(.MAX_SHIFT(26)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_fields(input string tag, input logic [7:0] e_sh, input logic e_ab,
                             input logic e_ps, input logic [25:0] e_al, input logic e_st);
      chk_val({tag, ".out_valid"},  32'(bus.out_valid),  32'd1);
      chk_val({tag, ".in_ready"},   32'(bus.in_ready),   32'd0);
      chk_val({tag, ".shamt"},      32'(bus.shamt),      32'(e_sh));
      chk_val({tag, ".ab_req"},     32'(bus.ab_req),     32'(e_ab));
      chk_val({tag, ".prod_shift"}, 32'(bus.prod_shift), 32'(e_ps));
      chk_val({tag, ".align_m"},    32'(bus.align_m),    32'(e_al));
      chk_val({tag, ".sticky"},     32'(bus.sticky),     32'(e_st));
   endtask

   task automatic chk_reset_outs(input string tag);
      chk_val({tag, ".out_valid"},  32'(bus.out_valid),  32'd0);
      chk_val({tag, ".busy"},       32'(bus.busy),       32'd0);
      chk_val({tag, ".in_ready"},   32'(bus.in_ready),   32'd1);
      chk_val({tag, ".shamt"},      32'(bus.shamt),      32'd0);
      chk_val({tag, ".ab_req"},     32'(bus.ab_req),     32'd0);
      chk_val({tag, ".prod_shift"}, 32'(bus.prod_shift), 32'd0);
      chk_val({tag, ".align_m"},    32'(bus.align_m),    32'd0);
      chk_val({tag, ".sticky"},     32'(bus.sticky),     32'd0);
   endtask

   // Present one operand set in the current IDLE cycle; returns after the accepting edge.
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [22:0] m);
      bus.in_valid = 1'b1;
      bus.exp_a    = a;
      bus.exp_b    = b;
      bus.exp_c    = c;
      bus.man_c    = m;
      tick();
      bus.in_valid = 1'b0;
      bus.exp_a    = 8'hxx;
      bus.exp_b    = 8'hxx;
      bus.exp_c    = 8'hxx;
      bus.man_c    = 23'hx;
   endtask

   task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [22:0] m,
                          input logic [7:0] e_sh, input logic e_ab, input logic e_ps,
                          input logic [25:0] e_al, input logic e_st,
                          input int e_lat, input int hold);
      int e;
      chk_val({tag, ".ready_before"}, 32'(bus.in_ready), 32'd1);
      launch(a, b, c, m);
      chk_val({tag, ".busy"}, 32'(bus.busy), 32'd1);
      e = 0;
      while (!bus.out_valid && e < 40) begin
         tick();
         e++;
      end
      if (!bus.out_valid) begin
         chk_val({tag, ".timeout"}, 32'(bus.out_valid), 32'd1);
         return;
      end
      // out_valid first seen after edge k+e means it is sampled high at edge k+e+1.
      chk_val({tag, ".latency"}, 32'(e + 1), 32'(e_lat));
      chk_fields(tag, e_sh, e_ab, e_ps, e_al, e_st);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk_fields({tag, ".hold"}, e_sh, e_ab, e_ps, e_al, e_st);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk_val({tag, ".post_valid"}, 32'(bus.out_valid), 32'd0);
      chk_val({tag, ".post_ready"}, 32'(bus.in_ready),  32'd1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.exp_a     = '0;
      bus.exp_b     = '0;
      bus.exp_c     = '0;
      bus.man_c     = '0;
      bus.in_valid  = 1'b1;
      repeat (3) tick();
      chk_reset_outs("reset");
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      chk_val("reset.no_capture", 32'(bus.busy), 32'd0);

      run_txn("v_sh3",   8'd10,  8'd5,   8'd12,  23'h7FFFFF, 8'd3,   1'b1, 1'b0, 26'h07FFFFF, 1'b1, 5,  0);
      run_txn("v_sat",   8'd60,  8'd40,  8'd0,   23'h000000, 8'd100, 1'b1, 1'b0, 26'h0000000, 1'b1, 28, 0);
      run_txn("v_triv",  8'd130, 8'd127, 8'd127, 23'h000000, 8'h82,  1'b0, 1'b0, 26'h2000000, 1'b0, 2,  0);
      run_txn("v_prod",  8'd1,   8'd1,   8'd5,   23'h123456, 8'hFD,  1'b1, 1'b1, 26'h248D158, 1'b0, 2,  5);
      // Issued in the very cycle after the held handshake: back-to-back acceptance.
      run_txn("v_b2b",   8'd10,  8'd5,   8'd12,  23'h7FFFFF, 8'd3,   1'b1, 1'b0, 26'h07FFFFF, 1'b1, 5,  0);
      run_txn("v_sh25",  8'd25,  8'd0,   8'd0,   23'h000000, 8'd25,  1'b1, 1'b0, 26'h0000001, 1'b0, 27, 0);
      run_txn("v_sh26",  8'd26,  8'd0,   8'd0,   23'h000000, 8'd26,  1'b1, 1'b0, 26'h0000000, 1'b1, 28, 0);
      run_txn("v_sh2",   8'd2,   8'd0,   8'd0,   23'h000000, 8'd2,   1'b1, 1'b0, 26'h0800000, 1'b0, 4,  0);
      run_txn("v_e8",    8'd0,   8'd0,   8'd24,  23'h000001, 8'hE8,  1'b0, 1'b0, 26'h2000004, 1'b0, 2,  0);
      run_txn("v_e9",    8'd0,   8'd0,   8'd23,  23'h000001, 8'hE9,  1'b1, 1'b1, 26'h2000004, 1'b0, 2,  0);

      launch(8'd60, 8'd40, 8'd0, 23'h000000);
      repeat (5) tick();
      chk_val("rst_mid.busy_before", 32'(bus.busy), 32'd1);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      tick();
      chk_reset_outs("rst_mid");
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      chk_val("rst_mid.no_capture", 32'(bus.busy), 32'd0);
      run_txn("v_after", 8'd10,  8'd5,   8'd12,  23'h7FFFFF, 8'd3,   1'b1, 1'b0, 26'h07FFFFF, 1'b1, 5,  0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fma_align_ctrl.md
FMA_ALIGN_CTRL -- requirements
Module: fma_align_ctrl

Interface
REQ-001 Parameter: MAX_SHIFT, 26, saturation limit for the addend right-shift count; equals the aligned mantissa width.
REQ-002 Clocking: one clock, clk; reset rst is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 exp_a, exp_b, exp_c  input  8 each  exponents of the multiplicands a, b and the addend c.
REQ-008 man_c  input  23  addend mantissa, hidden bit excluded.
REQ-009 out_valid  output  1  result fields valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 shamt  output  8  registered exp_a+exp_b-exp_c, modulo 256.
REQ-012 ab_req  output  1  product is non-trivial.
REQ-013 prod_shift  output  1  downstream must shift the product instead of the addend.
REQ-014 align_m  output  26  aligned addend mantissa.
REQ-015 sticky  output  1  OR of all bits shifted out of align_m.
REQ-016 busy  output  1  state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, CALC, SHIFT and DONE.
REQ-018 IDLE: in_ready=1; on in_valid, capture exp_a/b/c and man_c; go to CALC.
REQ-019 In all other states, in_ready SHALL be 0 and inputs SHALL be ignored.
REQ-020 CALC (1 cycle): compute shamt = exp_a+exp_b-exp_c with 8-bit wraparound.
REQ-021 CALC: ab_req = 0 when shamt[7]=1 and shamt[6:0] <= 104; otherwise ab_req = 1.
REQ-022 CALC: load align_m = {1, man_c, 2'b00}; clear sticky.
REQ-023 CALC shift count n: n = min(shamt, MAX_SHIFT) when ab_req=1 and shamt[7]=0; otherwise n = 0.
REQ-024 CALC: prod_shift = ab_req AND shamt[7].
REQ-025 CALC exit: if n=0, go to DONE; else go to SHIFT.
REQ-026 SHIFT, each cycle: align_m shifts right 1 bit with 0 in at the MSB; sticky |= outgoing LSB; counter decrements.
REQ-027 SHIFT exit: go to DONE on the cycle the counter goes 1->0, so exactly n shifts occur.
REQ-028 DONE: out_valid=1; shamt, ab_req, prod_shift, align_m and sticky SHALL remain stable until out_ready=1.
REQ-029 DONE with out_ready=1: the handshake completes that cycle; go to IDLE, so out_valid=0 and in_ready=1 in the next cycle.
REQ-030 Latency: input accepted at edge k gives out_valid high from edge k+2+n; worst case is k+28.
REQ-031 Throughput: one operand set per 3+n cycles at best; no input/output overlap.
REQ-032 Saturation: shamt >= 26 with ab_req=1 and shamt[7]=0 gives align_m=0 and sticky=1.
REQ-033 A trivial product (ab_req=0) gives no shift, prod_shift=0 and unshifted align_m.
REQ-034 out_valid SHALL be asserted only in DONE; busy = (state != IDLE).

Reset
REQ-035 When rst=1 at a clock edge, the state SHALL go to IDLE regardless of state, including mid-SHIFT or DONE with out_ready=0; the pending result is discarded.
REQ-036 Reset values: out_valid=0, busy=0, shamt=0, ab_req=0, prod_shift=0, align_m=0, sticky=0, counter=0; in_ready=1 in the first cycle after reset.
REQ-037 in_valid during reset SHALL NOT be captured.

Verification
REQ-038 exp_a=10, exp_b=5, exp_c=12, man_c=23'h7FFFFF -> shamt=3, ab_req=1, prod_shift=0, align_m=26'h07FFFFF, sticky=1, out_valid at k+5.
REQ-039 exp_a=60, exp_b=40, exp_c=0 -> shamt=100, saturated 26 shifts, align_m=0, sticky=1, out_valid at k+28.
REQ-040 exp_a=130, exp_b=127, exp_c=127, man_c=0 -> shamt=8'h82, ab_req=0, prod_shift=0, align_m=26'h2000000, sticky=0, out_valid at k+2.
REQ-041 exp_a=1, exp_b=1, exp_c=5 -> shamt=8'hFD, ab_req=1, prod_shift=1, no shift, out_valid at k+2.
REQ-042 Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle; a new in_valid is accepted that cycle.
REQ-043 Assert rst during SHIFT of the REQ-039 case -> next cycle IDLE with all outputs at reset values; a following REQ-038 transaction completes correctly.
